// File: rtl/s_mem_check.sv
// s_mem_check: sequential reader and checker for the RC4 S memory.
// Streams {addr, byte} pairs downstream and tallies mismatches against S[i] = i.
module s_mem_check #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic              rdy_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [7:0]        rddata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [7:0]        out_data_o,
    output logic [ADDR_W:0]   err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic              done_o,
    output logic              pass_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_OUT
    } state_e;

    state_e state_q, state_d;

    // addr_q doubles as the read index i; it only moves on an accepted transfer
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              done_q, done_d;

    logic start;
    logic capture;
    logic xfer;
    logic last;
    logic mismatch;
    logic [7:0] idx_byte;

    assign idx_byte = addr_q[7:0];
    assign last     = (addr_q == LAST);
    assign mismatch = (rddata_i != idx_byte);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one read, one latency cycle, then wait for the consumer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (en_i) state_d = S_RD;
            S_RD:   state_d = S_LAT;
            S_LAT:  state_d = S_OUT;
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = last ? S_IDLE : S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / strobe decode from the current state
    always_comb begin
        rdy_o   = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        xfer    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rdy_o = 1'b1;
                start = en_i;
            end
            S_LAT:  capture = 1'b1;
            S_OUT:  xfer = out_valid_q && out_ready_i;
            default: ;
        endcase
    end

    // Datapath next-state: counters clear on start, update on capture/transfer
    always_comb begin
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        first_d     = first_q;
        done_d      = done_q;
        if (start) begin
            addr_d  = '0;
            err_d   = '0;
            first_d = '0;
            done_d  = 1'b0;
        end
        if (capture) begin
            out_addr_d  = addr_q;
            out_data_d  = rddata_i;
            out_valid_d = 1'b1;
            if (mismatch) begin
                err_d = err_q + 1'b1;
                if (err_q == '0) begin
                    first_d = addr_q;
                end
            end
        end
        if (xfer) begin
            out_valid_d = 1'b0;
            if (last) begin
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            err_q       <= '0;
            first_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            first_q     <= first_d;
            done_q      <= done_d;
        end
    end

    assign addr_o           = addr_q;
    assign out_valid_o      = out_valid_q;
    assign out_addr_o       = out_addr_q;
    assign out_data_o       = out_data_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;
    assign done_o           = done_q;
    assign pass_o           = done_q && (err_q == '0);

endmodule
